ddr_burst_tester: RTL and testbench
===================================

# ddr_burst_tester

Parametrised Avalon-MM burst traffic generator and checker for the EMIF DDR user port, clocked by the EMIF user clock. On a start pulse it runs a write pass, a read pass, or a write-then-read-verify pass over `NUM_BURSTS` consecutive bursts of `BURST_LEN` beats each, beginning at `BASE_ADDR`. In read passes it compares returned data against the regenerated pattern and reports pass/fail, a mismatch count and timeouts. It replaces the fixed two-burst, button-driven test logic with a fully Avalon-compliant, waitrequest-respecting master.

## Interface
- `ADDR_W`, 25, word address width
- `DATA_W`, 64, data width; must be a multiple of 32
- `BURST_W`, 7, burstcount width
- `BURST_LEN`, 6, beats per burst; range 1..2^BURST_W-1
- `NUM_BURSTS`, 2, bursts per pass; minimum 1
- `BASE_ADDR`, 155196, first word address
- `SEED`, 32'h1234_5678, pattern seed
- `TIMEOUT`, 1023, max cycles spent in RD_WAIT per burst

- `clk`  in  1  EMIF user clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle start pulse; ignored while `busy`
- `mode`  in  2  sampled on `start`: 0 write only, 1 read-verify only, 2 write then read-verify, 3 treated as 2
- `amm_ready`  in  1  slave ready (inverse waitrequest)
- `amm_write`  out  1  write request
- `amm_read`  out  1  read request
- `amm_address`  out  ADDR_W  burst start address
- `amm_burstcount`  out  BURST_W  burst length
- `amm_writedata`  out  DATA_W  write beat data
- `amm_byteenable`  out  DATA_W/8  byte enables; always all ones
- `amm_readdata`  in  DATA_W  read data
- `amm_readdatavalid`  in  1  read beat valid
- `busy`  out  1  pass in progress
- `done`  out  1  high from pass completion until next accepted `start`
- `pass`  out  1  valid while `done`: 1 when err_cnt==0 and no timeout
- `timeout`  out  1  sticky; a read burst exceeded `TIMEOUT`
- `err_cnt`  out  16  mismatching read beats; saturates at 16'hFFFF

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_WAIT, DONE.
- IDLE: on `start`, clear `err_cnt`, `timeout`, `done`; set burst index 0 and beat index 0; go to WR_BURST if mode≠1, else RD_CMD.
- WR_BURST: `amm_write`=1; `amm_address`=BASE_ADDR+burst*BURST_LEN and `amm_burstcount`=BURST_LEN, both held constant for the whole burst. A beat is accepted when `amm_write&&amm_ready`; only then does the beat index and pattern advance. After beat BURST_LEN-1, advance to the next burst (write deasserted for exactly one cycle between bursts). After the last burst, go to DONE if mode==0, else RD_CMD with burst index 0.
- RD_CMD: `amm_read`=1 with the address and burstcount of the current burst, held until `amm_ready`, then go to RD_WAIT. One read burst is outstanding at a time.
- RD_WAIT: each `amm_readdatavalid` beat is compared against the expected pattern; on mismatch, `err_cnt` increments (saturating). After BURST_LEN beats, go to the next RD_CMD, or to DONE after the last burst. If the cycle counter reaches TIMEOUT: set `timeout` and go to DONE.
- DONE: `done`=1, `busy`=0, wait for `start` (same entry as IDLE).
- Pattern: word value w = word address (zero-extended to 32b) + SEED, mod 2^32. Beat data = w replicated DATA_W/32 times. Read compare regenerates it from the beat address.
- Address arithmetic is mod 2^ADDR_W; wrap past the top is silent.
- `amm_readdatavalid` outside RD_WAIT is ignored.
- `rst` mid-pass: all outputs return to reset values on the next edge; any outstanding Avalon transaction is abandoned, since the EMIF is reset together with this block.

## Timing
- Reset values: `amm_write`, `amm_read`, `busy`, `done`, `pass`, `timeout` = 0; `err_cnt`=0; `amm_address`=0; `amm_burstcount`=0; `amm_writedata`=0; `amm_byteenable`=all ones.
- All outputs are registered. `busy` rises the cycle after `start`, and the first `amm_write`/`amm_read` appears in the same cycle.
- With `amm_ready` held high, a write burst takes exactly BURST_LEN cycles, plus 1 idle cycle between bursts.
- Read compare result enters `err_cnt` 1 cycle after the valid beat. `done`/`pass` are asserted 2 cycles after the last beat, so the final compare is included.
- `start` while `busy` is ignored. `start` in DONE restarts the pass.

## Configuration
- `DDR_TESTER_LFSR_EN` defined: w is instead a 32-bit Galois LFSR (taps 32,22,2,1), loaded with SEED at the start of each write pass and each read pass. It steps once per accepted write beat and once per received read beat, so read order must match write order.
- Undefined: address-plus-SEED pattern as described above; no LFSR logic is present.

## Test plan
- mode=2, ready always 1, memory model echoes data → 12 write beats at addresses 155196/155202, 12 read beats, `done`=1, `pass`=1, `err_cnt`=0.
- ready toggled 1-0 every cycle during writes → `amm_writedata`/`amm_address` stable while ready=0; exactly 6 accepted beats per burst.
- model corrupts bit 0 of read beat 3 of burst 1 → `err_cnt`=1, `pass`=0.
- mode=1, model never returns readdatavalid, TIMEOUT=15 → `timeout`=1, `done`=1, `pass`=0 about 17 cycles after command accept.
- `rst` asserted mid WR_BURST (beat 2) → next cycle `amm_write`=0, `busy`=0; a new start then completes cleanly.
- `start` pulsed while `busy` → ignored; `err_cnt` not cleared, pass proceeds unchanged.

Source files
------------

// File: rtl/ddr_burst_tester_if.sv
// Avalon-MM burst master bundle for the EMIF DDR user port.
interface ddr_burst_tester_if #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 7
);
  logic                write;
  logic                read;
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                ready;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output write, read, address, burstcount, writedata, byteenable,
    input  ready, readdata, readdatavalid
  );
  modport slave (
    input  write, read, address, burstcount, writedata, byteenable,
    output ready, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr_burst_tester.sv
// Avalon-MM burst write / read-verify traffic generator for the EMIF user port.
// Optional DDR_TESTER_LFSR_EN swaps the address+SEED pattern for a Galois LFSR.

module ddr_burst_lane_cmp (
  input  logic [31:0] got,
  input  logic [31:0] exp,
  output logic        neq
);
  assign neq = (got != exp);
endmodule

module ddr_burst_tester #(
  parameter int          ADDR_W     = 25,
  parameter int          DATA_W     = 64,
  parameter int          BURST_W    = 7,
  parameter int          BURST_LEN  = 6,
  parameter int          NUM_BURSTS = 2,
  parameter int          BASE_ADDR  = 155196,
  parameter logic [31:0] SEED       = 32'h1234_5678,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  ddr_burst_tester_if.master  amm,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_cnt
);
  localparam int NUM_LANES = DATA_W / 32;
  localparam int BI_W      = $clog2(NUM_BURSTS + 1);
  localparam int TC_W      = $clog2(TIMEOUT + 2);

  localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(BURST_LEN);
  localparam logic [BURST_W-1:0] BLEN       = BURST_W'(BURST_LEN);
  localparam logic [BURST_W-1:0] LAST_BEAT  = BURST_W'(BURST_LEN - 1);
  localparam logic [BI_W-1:0]    LAST_BURST = BI_W'(NUM_BURSTS - 1);
  localparam logic [TC_W-1:0]    TMO        = TC_W'(TIMEOUT);

`ifdef DDR_TESTER_LFSR_EN
  localparam logic [31:0] FIRST_WORD = SEED;
`else
  localparam logic [31:0] FIRST_WORD = 32'(BASE) + SEED;
`endif

  typedef logic [NUM_LANES-1:0][31:0] lanes_t;
  typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT, DONE} state_t;

  function automatic lanes_t rep(input logic [31:0] w);
    lanes_t r;
    for (int i = 0; i < NUM_LANES; i++) r[i] = w;
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [BI_W-1:0]    burst_q, burst_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  lanes_t             wdata_q, wdata_d;
  logic               write_q, write_d;
  logic               read_q, read_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tmo_q, tmo_d;
  logic [15:0]        err_q, err_d;
  logic [TC_W-1:0]    tcnt_q, tcnt_d;
  logic               wr_only_q, wr_only_d;

  logic [31:0] wr_next_word;
  logic [31:0] rd_exp_word;

`ifdef DDR_TESTER_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign wr_next_word = lfsr_step(lfsr_q);
  assign rd_exp_word  = lfsr_q;
`else
  logic [ADDR_W-1:0] beat_addr;
  assign beat_addr    = addr_q + ADDR_W'(beat_q);
  // Crossing into the next burst lands on addr_q+STRIDE, which is also beat_addr+1.
  assign wr_next_word = 32'(beat_addr + ADDR_W'(1)) + SEED;
  assign rd_exp_word  = 32'(beat_addr) + SEED;
`endif

  lanes_t               rd_lanes;
  logic [NUM_LANES-1:0] lane_neq;
  logic                 beat_bad;

  assign rd_lanes = amm.readdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ddr_burst_lane_cmp u_cmp (
      .got (rd_lanes[g]),
      .exp (rd_exp_word),
      .neq (lane_neq[g])
    );
  end

  assign beat_bad = |lane_neq;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    read_d    = read_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    wr_only_d = wr_only_q;
`ifdef DDR_TESTER_LFSR_EN
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // done/pass trail DONE entry by a cycle so the final compare is in err_q
        if (state_q == DONE) begin
          done_d = 1'b1;
          pass_d = (err_q == 16'h0) && !tmo_q;
        end
        if (start) begin
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = 16'h0;
          tmo_d     = 1'b0;
          busy_d    = 1'b1;
          burst_d   = '0;
          beat_d    = '0;
          addr_d    = BASE;
          bcnt_d    = BLEN;
          wr_only_d = (mode == 2'd0);
`ifdef DDR_TESTER_LFSR_EN
          lfsr_d    = SEED;
`endif
          if (mode != 2'd1) begin
            state_d = WR_BURST;
            write_d = 1'b1;
            wdata_d = rep(FIRST_WORD);
          end else begin
            state_d = RD_CMD;
            read_d  = 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (!write_q) begin
          write_d = 1'b1;
        end else if (amm.ready) begin
          wdata_d = rep(wr_next_word);
`ifdef DDR_TESTER_LFSR_EN
          lfsr_d  = wr_next_word;
`endif
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BURST_W'(1);
          end else begin
            beat_d  = '0;
            write_d = 1'b0;
            if (burst_q != LAST_BURST) begin
              burst_d = burst_q + BI_W'(1);
              addr_d  = addr_q + STRIDE;
            end else if (wr_only_q) begin
              state_d = DONE;
              busy_d  = 1'b0;
            end else begin
              state_d = RD_CMD;
              read_d  = 1'b1;
              burst_d = '0;
              addr_d  = BASE;
`ifdef DDR_TESTER_LFSR_EN
              lfsr_d  = SEED;
`endif
            end
          end
        end
      end
      RD_CMD: begin
        if (read_q && amm.ready) begin
          read_d  = 1'b0;
          state_d = RD_WAIT;
          tcnt_d  = '0;
          beat_d  = '0;
        end
      end
      RD_WAIT: begin
        tcnt_d = tcnt_q + TC_W'(1);
        if (amm.readdatavalid) begin
          if (beat_bad && err_q != 16'hFFFF) err_d = err_q + 16'h1;
`ifdef DDR_TESTER_LFSR_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BURST_W'(1);
          end else begin
            beat_d = '0;
            if (burst_q != LAST_BURST) begin
              burst_d = burst_q + BI_W'(1);
              addr_d  = addr_q + STRIDE;
              read_d  = 1'b1;
              state_d = RD_CMD;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
            end
          end
        end else if (tcnt_q == TMO) begin
          tmo_d   = 1'b1;
          state_d = DONE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      bcnt_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= '0;
      tcnt_q    <= '0;
      wr_only_q <= 1'b0;
`ifdef DDR_TESTER_LFSR_EN
      lfsr_q    <= SEED;
`endif
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
      wr_only_q <= wr_only_d;
`ifdef DDR_TESTER_LFSR_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign amm.write      = write_q;
  assign amm.read       = read_q;
  assign amm.address    = addr_q;
  assign amm.burstcount = bcnt_q;
  assign amm.writedata  = wdata_q;
  assign amm.byteenable = '1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = tmo_q;
  assign err_cnt        = err_q;
endmodule

// File: tb/tb_ddr_burst_tester.sv
// Random-ready Avalon slave + memory model checking ddr_burst_tester against pass-level expectations.
module tb_ddr_burst_tester;
  localparam int          ADDR_W  = 25;
  localparam int          DATA_W  = 64;
  localparam int          BURST_W = 7;
  localparam int          L       = 6;
  localparam int          NB      = 2;
  localparam int          BASE    = 155196;
  localparam int          TMO     = 15;
  localparam logic [31:0] SEED    = 32'h1234_5678;
  localparam int          AMASK   = (1 << ADDR_W) - 1;
  localparam int          PASS_BEATS = L * NB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;

  ddr_burst_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) amm ();

  ddr_burst_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .BURST_LEN(L),
    .NUM_BURSTS(NB), .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amm(amm),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pattern, from address (default) or from beat position within a pass (LFSR).
  function automatic logic [63:0] pat_addr(input int a);
    logic [31:0] w;
    w = 32'(a & AMASK) + SEED;
    return {w, w};
  endfunction

`ifdef DDR_TESTER_LFSR_EN
  function automatic logic [63:0] pat_pos(input int n);
    logic [31:0] l;
    l = SEED;
    repeat (n) l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    return {l, l};
  endfunction
  function automatic logic [63:0] exp_wr(input int n);           return pat_pos(n); endfunction
  function automatic logic [63:0] exp_rd(input int n, input int a); return (a >= 0) ? pat_pos(n) : 64'h0; endfunction
`else
  function automatic logic [63:0] exp_wr(input int n);           return pat_addr(BASE + n); endfunction
  function automatic logic [63:0] exp_rd(input int n, input int a); return (n >= 0) ? pat_addr(a) : 64'h0; endfunction
`endif

  // Slave-side configuration (driven by the stimulus process only)
  int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random
  bit no_resp    = 1'b0;
  int corrupt_n  = -1;
  int corrupt_rate = 0;

  // Slave-side bookkeeping (owned by the slave process)
  logic [DATA_W-1:0] mem [int];
  int   rq_addr[$];
  int   r_k, wr_n, rd_n, rdcmd_n, exp_err, cmd_cyc, ra;
  bit   prev_busy, prev_stall, tog, last_gap;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data, rd;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      amm.ready = 1'b0; amm.readdatavalid = 1'b0; amm.readdata = '0;
      rq_addr.delete(); r_k = 0; prev_busy = 0; prev_stall = 0; last_gap = 0;
    end else begin
      if (busy && !prev_busy) begin
        wr_n = 0; rd_n = 0; rdcmd_n = 0; exp_err = 0; r_k = 0; rq_addr.delete();
      end
      prev_busy = busy;

      amm.readdatavalid = 1'b0;
      if (!no_resp && rq_addr.size() > 0 && (last_gap || $urandom_range(7) != 0)) begin
        ra = (rq_addr[0] + r_k) & AMASK;
        rd = mem.exists(ra) ? mem[ra] : '0;
        if (rd_n == corrupt_n || (corrupt_rate > 0 && $urandom_range(99) < corrupt_rate))
          rd[0] = ~rd[0];
        if (rd !== exp_rd(rd_n, ra)) exp_err++;
        amm.readdata = rd; amm.readdatavalid = 1'b1;
        rd_n++; r_k++; last_gap = 0;
        if (r_k == L) begin r_k = 0; void'(rq_addr.pop_front()); end
      end else begin
        last_gap = 1;
      end

      case (ready_mode)
        0:       amm.ready = 1'b1;
        1:       begin tog = !tog; amm.ready = tog; end
        default: amm.ready = 1'($urandom_range(1));
      endcase

      if (amm.write) begin
        if (prev_stall) begin
          chk("wr_addr_hold", 64'(amm.address), 64'(st_addr));
          chk("wr_data_hold", amm.writedata, st_data);
        end
        prev_stall = !amm.ready; st_addr = amm.address; st_data = amm.writedata;
        if (amm.ready) begin
          chk("wr_addr", 64'(amm.address), 64'((BASE + (wr_n / L) * L) & AMASK));
          chk("wr_bcnt", 64'(amm.burstcount), 64'(L));
          chk("wr_data", amm.writedata, exp_wr(wr_n));
          chk("wr_be",   64'(amm.byteenable), 64'hFF);
          mem[(BASE + wr_n) & AMASK] = amm.writedata;
          wr_n++;
        end
      end else begin
        prev_stall = 0;
      end

      if (amm.read && amm.ready) begin
        chk("rd_addr", 64'(amm.address), 64'((BASE + rdcmd_n * L) & AMASK));
        chk("rd_bcnt", 64'(amm.burstcount), 64'(L));
        rq_addr.push_back(int'(amm.address));
        rdcmd_n++; cmd_cyc = cyc;
      end
    end
  end

  task automatic go(input logic [1:0] m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("first_req", 64'((m == 2'd1) ? amm.read : amm.write), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic fin(input string tag, input logic [1:0] m, input bit tmo);
    int ew, er;
    ew = (m == 2'd1) ? 0 : PASS_BEATS;
    er = tmo ? 0 : ((m == 2'd0) ? 0 : PASS_BEATS);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_wr_beats"}, 64'(wr_n), 64'(ew));
    chk({tag, "_rd_beats"}, 64'(rd_n), 64'(er));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    chk({tag, "_timeout"}, 64'(timeout), 64'(tmo));
    chk({tag, "_pass"}, 64'(pass), 64'((exp_err == 0) && !tmo));
  endtask

  initial begin
    int n;
    logic [1:0] m;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);       chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);       chk("rst_timeout", 64'(timeout), 0);
    chk("rst_err", 64'(err_cnt), 0);     chk("rst_write", 64'(amm.write), 0);
    chk("rst_read", 64'(amm.read), 0);   chk("rst_addr", 64'(amm.address), 0);
    chk("rst_bcnt", 64'(amm.burstcount), 0);
    chk("rst_wdata", amm.writedata, 0);  chk("rst_be", 64'(amm.byteenable), 64'hFF);
    rst = 1'b0;

    // Clean write-then-verify
    go(2'd2); wait_done("basic"); fin("basic", 2'd2, 0);
    chk("basic_pass1", 64'(pass), 64'd1);

    // Toggled ready during write-only pass
    ready_mode = 1; go(2'd0); wait_done("toggle"); fin("toggle", 2'd0, 0);

    // Bit 0 flipped in beat 3 of burst 1
    ready_mode = 2; corrupt_n = L + 3;
    go(2'd2); wait_done("corrupt"); fin("corrupt", 2'd2, 0);
    chk("corrupt_err1", 64'(err_cnt), 64'd1);

    // Start while busy is ignored
    ready_mode = 0;
    go(2'd2);
    n = 0;
    while (err_cnt != 16'd1 && n < 500) begin @(negedge clk); n++; end
    chk("busy_err_seen", 64'(err_cnt), 64'd1);
    start = 1'b1; mode = 2'd0; @(negedge clk); start = 1'b0;
    chk("busy_start_err", 64'(err_cnt), 64'd1);
    chk("busy_start_busy", 64'(busy), 64'd1);
    wait_done("busystart"); fin("busystart", 2'd2, 0);
    corrupt_n = -1;

    // Read-only with no response -> timeout
    no_resp = 1'b1;
    go(2'd1); wait_done("tmo"); fin("tmo", 2'd1, 1);
    n = cyc - cmd_cyc;
    chk("tmo_latency_ok", 64'(n >= 16 && n <= 19), 64'd1);
    no_resp = 1'b0;

    // Reset in the middle of the first write burst
    go(2'd2);
    n = 0;
    while (wr_n < 3 && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1; @(negedge clk);
    chk("midrst_write", 64'(amm.write), 0);
    chk("midrst_read", 64'(amm.read), 0);
    chk("midrst_busy", 64'(busy), 0);
    rst = 1'b0;
    go(2'd2); wait_done("after_rst"); fin("after_rst", 2'd2, 0);

    // Randomised passes
    for (int it = 0; it < 10; it++) begin
      m = 2'($urandom_range(3));
      ready_mode = 2;
      corrupt_rate = ($urandom_range(1) != 0) ? 20 : 0;
      go(m);
      repeat ($urandom_range(20)) @(negedge clk);
      if (busy) begin start = 1'b1; mode = 2'($urandom_range(3)); @(negedge clk); start = 1'b0; end
      wait_done("rand");
      fin("rand", m, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
